// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared op encodings, sequencer states and datapath width
package cpu_defs_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add or restoring-subtract step per cycle on magnitudes, sign-corrected hi/lo
module muldiv_iter_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);
   import cpu_defs_pkg::*;
   logic [2*W:0]   acc_q, acc_d;
   logic [W-1:0]   x_q, x_d, y_q, y_d, a_q, a_d;
   logic           div_q, div_d, sa_q, sa_d, sb_q, sb_d;
   logic [W:0]     madd, dsub;
   logic [2*W-1:0] prod;
   logic [W-1:0]   rem, quo;
   always_comb begin
      sa_d  = load ? (op == OP_MULT || op == OP_DIV) && a[W-1] : sa_q;
      sb_d  = load ? (op == OP_MULT || op == OP_DIV) && b[W-1] : sb_q;
      x_d   = load ? (sa_d ? -a : a) : x_q;
      y_d   = load ? (sb_d ? -b : b) : y_q;
      a_d   = load ? a : a_q;
      div_d = load ? (op == OP_DIV || op == OP_DIVU) : div_q;
      madd  = acc_q[0] ? acc_q[2*W:W] + {1'b0, x_q} : acc_q[2*W:W];
      dsub  = acc_q[2*W-1:W-1] - {1'b0, y_q};
      // multiply shifts the multiplier out of the low half; divide shifts the quotient in
      acc_d = load ? {{(W+1){1'b0}}, div_d ? x_d : y_d}
            : !step ? acc_q
            : div_q ? (dsub[W] ? {acc_q[2*W-1:0], 1'b0} : {dsub, acc_q[W-2:0], 1'b1})
            : {1'b0, madd, acc_q[W-1:1]};
      prod  = (sa_q ^ sb_q) ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
      quo   = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem   = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      hi    = !div_q ? prod[2*W-1:W] : (y_q == '0 ? a_q : rem);
      lo    = !div_q ? prod[W-1:0] : (y_q == '0 ? '1 : quo);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         a_q   <= '0;
         div_q <= 1'b0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         x_q   <= x_d;
         y_q   <= y_d;
         a_q   <= a_d;
         div_q <= div_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
      end
   end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequences iterative mul/div and arbitrates the shared regfile write port for hi/lo
module hilo_muldiv_ctrl #(
   parameter int DATA_W    = cpu_defs_pkg::DATA_W,
   parameter int MAX_DEFER = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   input  logic              wb_we,
   input  logic [4:0]        wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   output logic              wb_stall,
   output logic              rf_we,
   output logic              rf_whl,
   output logic [4:0]        rf_wa,
   output logic [DATA_W-1:0] rf_wd3,
   output logic [DATA_W-1:0] rf_wd4,
   output logic              done
);
   import cpu_defs_pkg::*;
   localparam int CW = $clog2(DATA_W) + 1;
   localparam int DW = $clog2(MAX_DEFER + 1);
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     defer_q, defer_d;
   logic              load, step, hl_wr, wr;
   logic [DATA_W-1:0] hi, lo;
   muldiv_iter_core #(.W(DATA_W)) u_core (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .op   (op),
      .a    (a),
      .b    (b),
      .hi   (hi),
      .lo   (lo)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      defer_d = defer_q;
      load    = 1'b0;
      step    = 1'b0;
      hl_wr   = 1'b0;
      case (state_q)
         IDLE: begin
            load    = start;
            state_d = start ? CALC : IDLE;
            cnt_d   = '0;
         end
         CALC: begin
            step    = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(DATA_W - 1)) ? DONE : CALC;
         end
         DONE: begin
            // pipeline writeback wins until the result has waited MAX_DEFER cycles
            hl_wr   = !wb_we || defer_q == DW'(MAX_DEFER);
            state_d = hl_wr ? IDLE : DONE;
            defer_d = hl_wr ? '0 : defer_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         defer_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         defer_q <= defer_d;
      end
   end
   assign wr       = hl_wr && !rst;
   assign busy     = !rst && state_q != IDLE;
   assign rf_whl   = wr;
   assign done     = wr;
   assign wb_stall = wr && wb_we;
   assign rf_we    = wr || wb_we;
   assign rf_wa    = wr ? 5'd0 : wb_wa;
   assign rf_wd3   = wr ? lo : wb_wd;
   assign rf_wd4   = wr ? hi : '0;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: random and directed mul/div ops scored against an arithmetic reference model
module tb_hilo_muldiv_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, busy, wb_we, wb_stall, rf_we, rf_whl, done;
   logic [1:0]  op;
   logic [31:0] a, b, wb_wd, rf_wd3, rf_wd4;
   logic [4:0]  wb_wa, rf_wa;
   logic [63:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;

   hilo_muldiv_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .wb_we    (wb_we),
      .wb_wa    (wb_wa),
      .wb_wd    (wb_wd),
      .wb_stall (wb_stall),
      .rf_we    (rf_we),
      .rf_whl   (rf_whl),
      .rf_wa    (rf_wa),
      .rf_wd3   (rf_wd3),
      .rf_wd4   (rf_wd4),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      longint unsigned ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'h0, x};
      uy = {32'h0, y};
      case (o)
         2'd0: return 64'(sx * sy);
         2'd1: return ux * uy;
         2'd2: return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
         default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
      endcase
   endfunction

   always @(negedge clk) begin
      logic [63:0] e;
      if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_done actual=%h_%h expected=no_write at %0t", rf_wd4, rf_wd3, $time);
         end else begin
            e = exp_q.pop_front();
            chk("hilo", 80'({rf_wd4, rf_wd3}), 80'(e));
            chk("rf_we_whl", 80'({rf_we, rf_whl, rf_wa}), 80'({2'b11, 5'd0}));
         end
      end else begin
         chk("passthru", 80'({rf_we, rf_wa, rf_wd3, rf_wd4, rf_whl}), 80'({wb_we, wb_wa, wb_wd, 32'h0, 1'b0}));
      end
      chk("stall", 80'(wb_stall), 80'(done & wb_we));
   end

   // mode 0: no writeback, 1: writeback to r5 held, 2: random writeback every cycle
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int mode, input bit poke);
      int n;
      n = 0;
      @(posedge clk); #1;
      op = o; a = x; b = y; start = 1'b1;
      if (mode == 1) begin
         wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hAA;
      end else begin
         wb_we = (mode == 2) ? 1'($urandom) : 1'b0; wb_wa = 5'($urandom); wb_wd = $urandom;
      end
      exp_q.push_back(model(o, x, y));
      @(posedge clk); #1;
      start = 1'b0;
      while (1) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("busy_calc", 80'(busy), 80'(1));
         if (done || n >= 100) break;
         @(posedge clk); #1;
         start = poke && n == 5;
         if (start) begin
            op = ~o; a = $urandom; b = $urandom;
         end
         if (mode == 2) begin
            wb_we = 1'($urandom); wb_wa = 5'($urandom); wb_wd = $urandom;
         end
      end
      chk("done_seen", 80'(done), 80'(1));
      if (mode != 2) chk("latency", 80'(n), 80'(mode == 1 ? 37 : 33));
      @(negedge clk);
      chk("busy_after", 80'(busy), 80'(0));
      if (mode == 1) chk("repass", 80'({rf_we, rf_wa, rf_wd3}), 80'({1'b1, 5'd5, 32'hAA}));
      @(posedge clk); #1;
      wb_we = 1'b0;
   endtask

   initial begin
      logic [1:0]  o;
      logic [31:0] x, y;
      rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
      wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'd123;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 80'({busy, done, rf_whl, wb_stall, rf_wd4}), 80'(0));
      chk("reset_mirror", 80'({rf_we, rf_wa, rf_wd3}), 80'({1'b1, 5'd3, 32'd123}));
      @(posedge clk); #1;
      rst = 1'b0; wb_we = 1'b0;

      run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
      run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      run_op(2'd3, 32'd100, 32'd7, 0, 1'b0);
      run_op(2'd3, 32'h64, 32'd0, 0, 1'b0);
      run_op(2'd2, 32'h8000_0005, 32'd0, 0, 1'b0);
      run_op(2'd0, 32'd12345, 32'hFFFF_FD5A, 1, 1'b0);
      run_op(2'd2, 32'h8765_4321, 32'd77, 0, 1'b1);

      @(posedge clk); #1;
      op = 2'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("busy_in_rst", 80'(busy), 80'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", 80'(busy), 80'(0));
      repeat (40) @(negedge clk);
      chk("still_idle", 80'(busy), 80'(0));

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         x = ($urandom_range(0, 3) == 0) ? 32'($signed(8'($urandom))) : $urandom;
         y = ($urandom_range(0, 3) == 0) ? 32'($signed(6'($urandom))) : $urandom;
         if ($urandom_range(0, 7) == 0) y = 32'd0;
         run_op(o, x, y, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      end
      repeat (3) @(negedge clk);
      chk("queue_empty", 80'(exp_q.size()), 80'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequencer for MIPS MULT/MULTU/DIV/DIVU. It runs an iterative 32-step multiply or divide and holds the result until the regfile write port is free. It then writes hi/lo through the regfile's shared write port (we3/whl/wd3/wd4). The block sits between the EX stage and the regfile, arbitrating that single write port against normal pipeline writeback.

Parameters:
DATA_W, 32, operand/result width (iteration count equals DATA_W)
MAX_DEFER, 4, cycles a ready result may wait behind pipeline writeback before the block forces priority

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request new operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  DATA_W  rs operand (multiplicand / dividend)
b  in  DATA_W  rt operand (multiplier / divisor)
busy  out  1  high in CALC and DONE; EX stalls any hi/lo consumer while high
wb_we  in  1  pipeline writeback request
wb_wa  in  5  pipeline writeback address
wb_wd  in  DATA_W  pipeline writeback data
wb_stall  out  1  pipeline must hold its writeback this cycle
rf_we  out  1  to regfile we3
rf_whl  out  1  to regfile whl (1 = hi/lo write)
rf_wa  out  5  to regfile wa3
rf_wd3  out  DATA_W  to regfile wd3 (lo when rf_whl)
rf_wd4  out  DATA_W  to regfile wd4 (hi when rf_whl)
done  out  1  one-cycle pulse, equal to rf_whl

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, wb_stall=0, rf_whl=0, done=0, defer counter=0, result regs=0. rf_we/rf_wa/rf_wd3 mirror the wb_* inputs even during reset.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at edge E0 latches op/a/b (signed ops take absolute values and record sign flags). Next state is CALC; count=0.
- CALC: one shift-add (mult) or restoring-subtract (div) step per cycle. After DATA_W steps (edge E32 for DATA_W=32), sign-correct the result and go to DONE. start is ignored while busy.
- Sign rules: MULT gives two's-complement 64-bit product. DIV quotient truncates toward zero; remainder takes the dividend's sign.
- Result placement: hi = product[63:32] or remainder; lo = product[31:0] or quotient.
- Divide by zero (DIV or DIVU): hi=a, lo=all ones. Still takes the full DATA_W cycles.
- DONE, wb_we=0: rf_we=1, rf_whl=1, rf_wd4=hi, rf_wd3=lo, done=1. Return to IDLE at that edge, so the earliest write is at E33.
- DONE, wb_we=1 and defer<MAX_DEFER: the pipeline write passes through (rf_whl=0), defer increments, and the block stays in DONE.
- DONE, defer==MAX_DEFER: the hi/lo write wins and wb_stall=1 for that cycle. The pipeline re-presents its write the next cycle.
- Outside a hi/lo write: rf_we=wb_we, rf_wa=wb_wa, rf_wd3=wb_wd, rf_wd4=0, rf_whl=0.
- Back-to-back: start is accepted in IDLE the cycle after DONE exits. There is no same-cycle overlap.
- rst mid-CALC or mid-DONE: the result is discarded, no hi/lo write occurs, and the block is in IDLE the next cycle.
- Widths: internal accumulator is 2*DATA_W+1 bits. The counter is $clog2(DATA_W)+1 bits.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, CALC, DONE);
  - the DATA_W constant.
- One sub-module, muldiv_iter_core: the iterative datapath, controlled by load and step, providing hi/lo outputs.
- hilo_muldiv_ctrl keeps the FSM, defer counter and port mux.

Test Plan:
- MULT a=FFFFFFFD (-3), b=5, wb_we=0 -> busy for 33 cycles; at E33 rf_whl=1, rf_wd4=FFFFFFFF, rf_wd3=FFFFFFF1, done=1 for 1 cycle.
- MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=00000064, b=0 -> hi=00000064, lo=FFFFFFFF after the full 33 cycles.
- Contention: wb_we=1 (wa=5, wd=AA) held throughout DONE -> 4 cycles of pass-through to reg 5. Cycle 5 gives wb_stall=1 and rf_whl=1. The next cycle returns to pass-through.
- rst asserted at CALC count 10 -> IDLE next cycle, busy=0, no rf_whl pulse. start during CALC is ignored (result matches the first operands).
